// File: rtl/pc_pkg.sv
// Shared types and default parameters for the IF-stage program-counter unit.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_RETURN = 2'd3
  } pc_sel_e;

  localparam int          PC_XLEN         = 32;
  localparam int          PC_INSTR_BYTES  = 4;
  localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] PC_TRAP_VECTOR  = 32'h0000_0100;
  localparam int          PC_RAS_DEPTH    = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: on a full push the oldest entry is overwritten,
// and a simultaneous pop+push replaces the top entry in place.
module pc_ras #(
  parameter  int XLEN      = 32,
  parameter  int RAS_DEPTH = 4,
  localparam int PW        = $clog2(RAS_DEPTH),
  localparam int CW        = PW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top_data,
  output logic [CW-1:0]   count,
  output logic            empty,
  output logic            full
);

  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

  logic [XLEN-1:0] mem_r [RAS_DEPTH];
  logic [PW-1:0]   top_r;
  logic [PW-1:0]   top_nx_s;
  logic [PW-1:0]   wr_idx_s;
  logic            wr_en_s;
  logic [CW-1:0]   count_r;
  logic [CW-1:0]   count_nx_s;
  logic            empty_r;
  logic            full_r;
  logic            pop_ok_s;

  // Next pointer/count and write slot; pop-then-push lands on the current top.
  always_comb begin
    pop_ok_s   = pop && (count_r != {CW{1'b0}});
    top_nx_s   = top_r;
    count_nx_s = count_r;
    wr_en_s    = 1'b0;
    wr_idx_s   = top_r;
    case ({push, pop_ok_s})
      2'b10: begin
        top_nx_s = top_r + PW'(1'b1);
        wr_en_s  = 1'b1;
        wr_idx_s = top_r + PW'(1'b1);
        if (count_r != DEPTH_C) begin
          count_nx_s = count_r + CW'(1'b1);
        end else begin
          count_nx_s = count_r;
        end
      end
      2'b01: begin
        top_nx_s   = top_r - PW'(1'b1);
        count_nx_s = count_r - CW'(1'b1);
      end
      2'b11: begin
        wr_en_s  = 1'b1;
        wr_idx_s = top_r;
      end
      default: begin
        top_nx_s   = top_r;
        count_nx_s = count_r;
      end
    endcase
  end

  // Pointer, occupancy and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      top_r   <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
      empty_r <= 1'b1;
      full_r  <= 1'b0;
    end else begin
      top_r   <= top_nx_s;
      count_r <= count_nx_s;
      empty_r <= (count_nx_s == {CW{1'b0}});
      full_r  <= (count_nx_s == DEPTH_C);
    end
  end

  // Entry storage; contents are don't-care after reset, but a push in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (wr_en_s && !rst) begin
      mem_r[wr_idx_s] <= push_data;
    end
  end

  assign top_data = mem_r[top_r];
  assign count    = count_r;
  assign empty    = empty_r;
  assign full     = full_r;

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC select, trap/stall priority, return-address stack,
// and misaligned-redirect detection. All outputs come straight from registers.
module pc_unit
  import pc_pkg::*;
#(
  parameter  int              XLEN         = PC_XLEN,
  parameter  int              INSTR_BYTES  = PC_INSTR_BYTES,
  parameter  logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_RESET_VECTOR),
  parameter  logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(PC_TRAP_VECTOR),
  parameter  int              RAS_DEPTH    = PC_RAS_DEPTH,
  localparam int              CW           = $clog2(RAS_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            trap,
  input  pc_sel_e         pc_sel,
  input  logic [XLEN-1:0] branch_offset,
  input  logic [XLEN-1:0] jump_target,
  input  logic            call_push,
  output logic [XLEN-1:0] pc,
  output logic [CW-1:0]   ras_count,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_miss,
  output logic            misalign_err
);

  localparam logic [XLEN-1:0] STEP_C     = XLEN'(INSTR_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);
  localparam logic [XLEN-1:0] BIT0_CLR   = {{(XLEN-1){1'b1}}, 1'b0};

  function automatic logic misaligned(input logic [XLEN-1:0] t);
    return (t & ALIGN_MASK) != {XLEN{1'b0}};
  endfunction

  logic [XLEN-1:0] pc_r;
  logic            miss_r;
  logic            mis_r;
  logic [XLEN-1:0] link_s;
  logic [XLEN-1:0] target_s;
  logic [XLEN-1:0] ras_top_s;
  logic            redirect_s;
  logic            sel_pop_s;
  logic            miss_s;
  logic            mis_s;
  logic            act_s;
  logic            pop_en_s;
  logic            push_en_s;

  // Next-PC target selection and event detection for the current pc_sel.
  always_comb begin
    link_s     = pc_r + STEP_C;
    target_s   = link_s;
    redirect_s = 1'b0;
    sel_pop_s  = 1'b0;
    miss_s     = 1'b0;
    case (pc_sel)
      PC_SEQ: begin
        target_s = link_s;
      end
      PC_BRANCH: begin
        target_s   = pc_r + branch_offset;
        redirect_s = 1'b1;
      end
      PC_JUMP: begin
        target_s   = jump_target & BIT0_CLR;
        redirect_s = 1'b1;
      end
      PC_RETURN: begin
        redirect_s = 1'b1;
        if (!ras_empty) begin
          target_s  = ras_top_s;
          sel_pop_s = 1'b1;
        end else begin
          target_s = jump_target & BIT0_CLR;
          miss_s   = 1'b1;
        end
      end
      default: begin
        target_s = link_s;
      end
    endcase
    mis_s     = redirect_s && misaligned(target_s);
    act_s     = !trap && !stall;
    pop_en_s  = act_s && sel_pop_s;
    push_en_s = act_s && call_push;
  end

  // PC and one-cycle event pulses; priority rst > trap > stall > pc_sel.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r   <= RESET_VECTOR;
      miss_r <= 1'b0;
      mis_r  <= 1'b0;
    end else if (trap) begin
      pc_r   <= TRAP_VECTOR;
      miss_r <= 1'b0;
      mis_r  <= 1'b0;
    end else if (stall) begin
      pc_r   <= pc_r;
      miss_r <= 1'b0;
      mis_r  <= 1'b0;
    end else begin
      pc_r   <= mis_s ? TRAP_VECTOR : target_s;
      miss_r <= miss_s;
      mis_r  <= mis_s;
    end
  end

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push_en_s),
    .pop       (pop_en_s),
    .push_data (link_s),
    .top_data  (ras_top_s),
    .count     (ras_count),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  assign pc           = pc_r;
  assign ras_miss     = miss_r;
  assign misalign_err = mis_r;

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit for the pipelined core. It is the successor to the single-mode PC register. It adds:
- selectable next-PC modes: sequential, PC-relative branch, absolute jump, return;
- a circular return-address stack (RAS);
- a trap redirect;
- misaligned-target detection;
- a configurable reset vector.

It sits in IF and drives the instruction-memory address. Its redirect and stall inputs come from the EX and hazard-detection stages.

Parameters:
- XLEN, 32, PC/offset/target width in bits.
- INSTR_BYTES, 4, sequential increment and alignment granule; power of two, 2 or 4.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC value loaded on trap or misaligned redirect.
- RAS_DEPTH, 4, RAS entries; power of two, 2..16.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  load-use hazard; hold PC.
- trap  in  1  exception; redirect to TRAP_VECTOR.
- pc_sel  in  2  next-PC mode (pc_sel_e).
- branch_offset  in  XLEN  signed offset for BRANCH.
- jump_target  in  XLEN  absolute target for JUMP; fallback target for RETURN.
- call_push  in  1  push return address (PC+INSTR_BYTES) this cycle.
- pc  out  XLEN  current fetch PC.
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_empty  out  1  ras_count==0.
- ras_full  out  1  ras_count==RAS_DEPTH.
- ras_miss  out  1  registered one-cycle pulse: RETURN taken with empty RAS.
- misalign_err  out  1  registered one-cycle pulse: redirect target misaligned.

Behaviour:
- Reset (rst=1 at edge), which overrides everything:
  - pc=RESET_VECTOR, ras_count=0, ras_miss=0, misalign_err=0.
  - RAS storage contents are don't-care.
  - Reset mid-operation discards any pending redirect or push.
- Priority per edge: rst > trap > stall > pc_sel.
- trap=1: pc<=TRAP_VECTOR. RAS unchanged; call_push and pc_sel ignored. Trap overrides stall.
- stall=1 (no trap): pc, RAS, ras_miss and misalign_err all hold 0 / current values as follows:
  - pc and RAS hold.
  - call_push and pc_sel are ignored.
  - ras_miss and misalign_err go to 0.
- pc_sel decode (not stalled):
  - SEQ (0): target = pc+INSTR_BYTES.
  - BRANCH (1): target = pc+branch_offset.
  - JUMP (2): target = jump_target with bit0 cleared.
  - RETURN (3):
    - RAS non-empty: target = top entry; pop.
    - RAS empty: target = jump_target with bit0 cleared; ras_miss<=1 next cycle.
- Arithmetic is modulo 2^XLEN; wrap-around is silent (pc=FFFF_FFFC, SEQ -> 0).
- Alignment: if target[$clog2(INSTR_BYTES)-1:0]!=0 for BRANCH, JUMP or RETURN:
  - pc<=TRAP_VECTOR and misalign_err<=1 for one cycle.
  - The pop/push still occurs.
- Latency: the new pc is visible the cycle after the edge where its inputs are sampled. No combinational path from inputs to pc.
- RAS push (call_push=1, not stalled, not trap): writes pc+INSTR_BYTES (the current pc's link) at top.
  - Full: overwrite the oldest entry (circular; top pointer advances modulo RAS_DEPTH); ras_count saturates at RAS_DEPTH.
- Simultaneous pop and push (RETURN with call_push):
  - Pop happens first; the popped value is the target.
  - The link then replaces the top entry; ras_count unchanged.
  - Pop on empty with push: count becomes 1.
- Push with SEQ/BRANCH/JUMP is legal; a JUMP with call_push is the normal call.
- ras_miss and misalign_err clear to 0 on any cycle without a new event.

Decomposition:
- Package pc_pkg:
  - typedef enum logic [1:0] pc_sel_e {PC_SEQ, PC_BRANCH, PC_JUMP, PC_RETURN};
  - localparam defaults for XLEN, INSTR_BYTES, RESET_VECTOR, TRAP_VECTOR.
- Sub-module pc_ras (parameters XLEN, RAS_DEPTH):
  - inputs: clk, rst, push, pop, push_data;
  - outputs: top_data, count, empty, full;
  - owns the circular storage, top pointer, and pop-then-push ordering.
- pc_unit holds next-PC mux, priority, alignment check and pulse registers.

Test Plan:
1. Reset then 3 cycles SEQ -> pc 0,4,8,C; ras_count=0; all pulses 0.
2. At pc=0x10, BRANCH offset 0xFFFF_FFF8 with stall=1 for 2 cycles, then stall=0:
   - pc holds 0x10 for 2 cycles;
   - then pc=0x08 (negative offset).
3. At pc=0x20, JUMP target 0x200 with call_push:
   - pc=0x200, RAS top=0x24, count=1;
   - later RETURN -> pc=0x24, count=0.
4. RAS_DEPTH=4: 5 calls with links L1..L5, then 5 RETURNs:
   - pcs are L5,L4,L3,L2, then jump_target;
   - ras_miss pulses only on the 5th RETURN; ras_full high after the 4th call.
5. JUMP target 0x102 (INSTR_BYTES=4) -> pc=TRAP_VECTOR (0x100), misalign_err=1 for exactly one cycle. Same cycle with trap=1 and stall=1 -> pc=0x100, RAS untouched.
6. pc=0xFFFF_FFFC, SEQ -> pc=0; rst asserted mid-sequence with RETURN pending -> pc=RESET_VECTOR, ras_count=0 the next cycle.
